// File: rtl/ssd1306_spi_tx.sv
// SSD1306 byte-wide SPI mode-0 transmitter, MSB first, CS# framing.
// Optional SSD1306_SPI_CS_GAP_EN adds a minimum CS# high time after a frame.
module ssd1306_spi_tx #(
  parameter int CLK_DIV       = 2,
  parameter int CS_GAP_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       spi_tx_trigger_in,
  input  logic [7:0] spi_data_in,
  input  logic       spi_last_byte_in,
  output logic       spi_ready_out,
  output logic       oled_sclk_out,
  output logic       oled_mosi_out,
  output logic       oled_csn_out
);

  localparam int DIV_MAX =
    (CLK_DIV > CS_GAP_CYCLES) ? CLK_DIV : CS_GAP_CYCLES;
  localparam int DW = $clog2(DIV_MAX + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
`ifdef SSD1306_SPI_CS_GAP_EN
  localparam logic [DW-1:0] GAP_LOAD = DW'(CS_GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_END
`ifdef SSD1306_SPI_CS_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [6:0]    shift_r, shift_n;
  logic          last_r, last_n;
  logic          sclk_n, mosi_n, csn_n;
  logic          tick;

  assign spi_ready_out = (state == S_IDLE);
  assign tick          = (div_cnt == '0);

  // State and registered pin outputs; reset releases CS# at once.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      shift_r       <= '0;
      last_r        <= 1'b0;
      oled_sclk_out <= 1'b0;
      oled_mosi_out <= 1'b0;
      oled_csn_out  <= 1'b1;
    end else begin
      state         <= state_n;
      div_cnt       <= div_n;
      bit_cnt       <= bit_n;
      shift_r       <= shift_n;
      last_r        <= last_n;
      oled_sclk_out <= sclk_n;
      oled_mosi_out <= mosi_n;
      oled_csn_out  <= csn_n;
    end
  end

  // Next state; every timed state exits when its divider reaches zero.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_r;
    last_n  = last_r;
    sclk_n  = oled_sclk_out;
    mosi_n  = oled_mosi_out;
    csn_n   = oled_csn_out;
    if (state != S_IDLE && !tick)
      div_n = div_cnt - DW'(1);
    unique case (state)
      S_IDLE: begin
        if (spi_tx_trigger_in) begin
          shift_n = spi_data_in[6:0];
          last_n  = spi_last_byte_in;
          mosi_n  = spi_data_in[7];
          csn_n   = 1'b0;
          bit_n   = 3'd7;
          div_n   = DIV_LOAD;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          sclk_n  = 1'b1;
          div_n   = DIV_LOAD;
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tick) begin
          sclk_n = 1'b0;
          div_n  = DIV_LOAD;
          if (bit_cnt == 3'd0) begin
            state_n = S_END;
          end else begin
            mosi_n  = shift_r[6];
            shift_n = {shift_r[5:0], 1'b0};
            bit_n   = bit_cnt - 3'd1;
            state_n = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (tick) begin
          sclk_n  = 1'b1;
          div_n   = DIV_LOAD;
          state_n = S_HIGH;
        end
      end
      S_END: begin
        if (tick) begin
          div_n   = DIV_LOAD;
          state_n = S_IDLE;
          if (last_r) begin
            csn_n = 1'b1;
`ifdef SSD1306_SPI_CS_GAP_EN
            div_n   = GAP_LOAD;
            state_n = S_GAP;
`endif
          end
        end
      end
`ifdef SSD1306_SPI_CS_GAP_EN
      S_GAP: begin
        if (tick) begin
          div_n   = DIV_LOAD;
          state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule
